bscan_dr_bridge: RTL and testbench

- Parametrised JTAG user-data-register bridge that sits behind the BSCAN primitive wrapper.
- It oversamples the TAP control outputs (DRCK, SEL, CAPTURE, SHIFT, UPDATE, RESET, TDI) in the fabric clock domain.
- It implements a DR_W-bit scan register, a host-to-FPGA word stream with a small output FIFO, and an FPGA-to-host single-word holding register.
- Both directions use valid/ready handshakes, so Bluespec-side logic can exchange words with a host over JTAG without touching the TCK domain.

---
 rtl/bscan_dr_bridge_pkg.sv | 31 +++
 rtl/bscan_dr_bridge_fifo.sv | 48 ++++
 rtl/bscan_dr_bridge.sv | 153 +++++++++++++++
 tb/tb_bscan_dr_bridge.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bscan_dr_bridge_pkg.sv
// Shared layout helpers for the JTAG user-DR bridge.
// Optional status fields are enabled by the macro BSCAN_DR_BRIDGE_STATUS_EN.
package bscan_dr_bridge_pkg;

`ifdef BSCAN_DR_BRIDGE_STATUS_EN
    localparam int STATUS_BITS = 2;
`else
    localparam int STATUS_BITS = 0;
`endif

    // Total scan register length for a given payload width
    function automatic int dr_w(input int data_width);
        return data_width + 1 + STATUS_BITS;
    endfunction

    // Host-to-FPGA word valid flag / FPGA-to-host word valid, always the MSB
    function automatic int flag_pos(input int data_width);
        return dr_w(data_width) - 1;
    endfunction

    // FIFO-full status bit (only meaningful with status fields enabled)
    function automatic int full_pos(input int data_width);
        return data_width + 1;
    endfunction

    // Overflow status / write-1-to-clear bit (only with status fields enabled)
    function automatic int ovf_pos(input int data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/bscan_dr_bridge_fifo.sv
// Small synchronous FIFO for host-to-FPGA words. A push into a full FIFO
// succeeds when a pop happens in the same cycle; otherwise it is ignored.
module bscan_dr_bridge_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/bscan_dr_bridge.sv
// JTAG user-DR bridge: oversamples the BSCAN TAP outputs in the CLK domain,
// runs a scan register, feeds host words into a FIFO and offers one
// FPGA-to-host holding word. Define BSCAN_DR_BRIDGE_STATUS_EN to add the
// fifo_full/overflow status fields and write-1-to-clear of overflow.
module bscan_dr_bridge
    import bscan_dr_bridge_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int OUT_DEPTH   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  jtag_drck,
    input  logic                  jtag_sel,
    input  logic                  jtag_capture,
    input  logic                  jtag_shift,
    input  logic                  jtag_update,
    input  logic                  jtag_reset,
    input  logic                  jtag_tdi,
    output logic                  jtag_tdo,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow
);
    localparam int DR_W     = dr_w(DATA_WIDTH);
    localparam int FLAG_POS = flag_pos(DATA_WIDTH);
`ifdef BSCAN_DR_BRIDGE_STATUS_EN
    localparam int FULL_POS = full_pos(DATA_WIDTH);
    localparam int OVF_POS  = ovf_pos(DATA_WIDTH);
`endif

    logic [6:0]            jsync_p [SYNC_STAGES];
    logic [6:0]            jin_s;
    logic                  drck_s, sel_s, capture_s, shift_s, update_s, jreset_s, tdi_s;
    logic                  drck_prev, upd_prev;
    logic                  drck_rise, upd_fire;
    logic [DR_W-1:0]       shreg;
    logic [DR_W-1:0]       cap_word;
    logic                  cap_had_valid;
    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  fifo_push, fifo_full, fifo_empty, fifo_drop;
    logic [$clog2(OUT_DEPTH):0] fifo_count;

    assign jin_s     = jsync_p[SYNC_STAGES-1];
    assign drck_s    = jin_s[0];
    assign sel_s     = jin_s[1];
    assign capture_s = jin_s[2];
    assign shift_s   = jin_s[3];
    assign update_s  = jin_s[4];
    assign jreset_s  = jin_s[5];
    assign tdi_s     = jin_s[6];

    assign drck_rise = drck_s & ~drck_prev & sel_s;
    assign upd_fire  = update_s & ~upd_prev & sel_s;

`ifdef BSCAN_DR_BRIDGE_STATUS_EN
    assign cap_word = {tx_valid, fifo_full, overflow, tx_data};
`else
    assign cap_word = {tx_valid, tx_data};
`endif

    // Synchroniser chain for all TAP signals plus the edge-detect history
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) jsync_p[i] <= '0;
            drck_prev <= 1'b0;
            upd_prev  <= 1'b0;
        end else begin
            jsync_p[0] <= {jtag_tdi, jtag_reset, jtag_update, jtag_shift,
                           jtag_capture, jtag_sel, jtag_drck};
            for (int i = 1; i < SYNC_STAGES; i++) jsync_p[i] <= jsync_p[i-1];
            drck_prev <= drck_s;
            upd_prev  <= update_s;
        end
    end

    // Scan register: capture has priority over shift; TAP reset wipes the scan
    always_ff @(posedge CLK) begin
        if (RST || jreset_s) begin
            shreg         <= '0;
            cap_had_valid <= 1'b0;
        end else begin
            if (upd_fire) cap_had_valid <= 1'b0;
            if (drck_rise) begin
                if (capture_s) begin
                    shreg         <= cap_word;
                    cap_had_valid <= tx_valid;
                end else if (shift_s) begin
                    shreg <= {tdi_s, shreg[DR_W-1:1]};
                end
            end
        end
    end

    // TDO follows the scan LSB one cycle later
    always_ff @(posedge CLK) begin
        if (RST || jreset_s) jtag_tdo <= 1'b0;
        else                 jtag_tdo <= shreg[0];
    end

    // FPGA-to-host holding register; consumed by the update after a capture that saw it
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (in_valid && !tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= in_data;
        end else if (upd_fire && cap_had_valid) begin
            tx_valid <= 1'b0;
        end
    end

    assign in_ready  = ~tx_valid;
    assign fifo_push = upd_fire & shreg[FLAG_POS];
    assign fifo_drop = fifo_push & fifo_full & ~(out_ready & ~fifo_empty);
    assign out_valid = (fifo_count != '0);

    // Sticky overflow; a drop in the same cycle as a host clear keeps it set
    always_ff @(posedge CLK) begin
        if (RST) begin
            overflow <= 1'b0;
        end else if (fifo_drop) begin
            overflow <= 1'b1;
`ifdef BSCAN_DR_BRIDGE_STATUS_EN
        end else if (upd_fire && shreg[OVF_POS]) begin
            overflow <= 1'b0;
`endif
        end
    end

    bscan_dr_bridge_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (fifo_push),
        .pop   (out_ready),
        .wdata (shreg[DATA_WIDTH-1:0]),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_bscan_dr_bridge.sv
// Directed bench for bscan_dr_bridge with a scoreboard queue of host words.
module tb_bscan_dr_bridge;
    import bscan_dr_bridge_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int SS    = 2;
    localparam int DRW   = dr_w(DW);
    localparam int FLAG  = flag_pos(DW);
    localparam int FULLP = full_pos(DW);
    localparam int OVFP  = ovf_pos(DW);

    logic          CLK, RST;
    logic          jtag_drck, jtag_sel, jtag_capture, jtag_shift;
    logic          jtag_update, jtag_reset, jtag_tdi, jtag_tdo;
    logic [DW-1:0] in_data, out_data;
    logic          in_valid, in_ready, out_valid, out_ready, overflow;

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_q[$];
    logic [63:0]   rd;
    logic [63:0]   last_wr;
    logic          exp_ovf;

    bscan_dr_bridge #(.DATA_WIDTH(DW), .OUT_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
        .CLK(CLK), .RST(RST),
        .jtag_drck(jtag_drck), .jtag_sel(jtag_sel), .jtag_capture(jtag_capture),
        .jtag_shift(jtag_shift), .jtag_update(jtag_update), .jtag_reset(jtag_reset),
        .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic logic [63:0] mk_word(input logic flag, input logic [DW-1:0] data);
        logic [63:0] w;
        w = 64'(data);
        w[FLAG] = flag;
        return w;
    endfunction

    function automatic logic [63:0] cap_exp(input logic tv, input logic full,
                                            input logic ovf, input logic [DW-1:0] data);
        logic [63:0] w;
        w = mk_word(tv, data);
`ifdef BSCAN_DR_BRIDGE_STATUS_EN
        w[FULLP] = full;
        w[OVFP]  = ovf;
`endif
        return w;
    endfunction

    // Pop the head when the DUT offers it and compare to the scoreboard
    task automatic pop_check(input string tag);
        int k;
        logic [DW-1:0] e;
        k = 0;
        while (!out_valid && k < 20) begin
            tick(1);
            k++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check(tag, 64'(out_data), 64'(e));
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
    endtask

    task automatic drck_pulse(input logic cap, input logic sh, input logic td);
        jtag_capture = cap;
        jtag_shift   = sh;
        jtag_tdi     = td;
        tick(1);
        jtag_drck = 1'b1;
        tick(4);
        jtag_drck = 1'b0;
        tick(4);
    endtask

    // Update pulse; optionally hold out_ready exactly on the push cycle
    task automatic update_pulse(input bit pop_with);
        logic [DW-1:0] e;
        jtag_capture = 1'b0;
        jtag_shift   = 1'b0;
        tick(1);
        jtag_update = 1'b1;
        if (pop_with) begin
            tick(SS);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            check("pop_on_update", 64'(out_data), 64'(e));
            out_ready = 1'b1;
            tick(1);
            out_ready = 1'b0;
            tick(4 - SS - 1);
        end else begin
            tick(4);
        end
        jtag_update = 1'b0;
        tick(4);
    endtask

    task automatic scan(input logic s, input logic [63:0] wr,
                        output logic [63:0] rdv, input bit pop_with);
        jtag_sel = s;
        tick(1);
        drck_pulse(1'b1, 1'b0, 1'b0);
        rdv = '0;
        for (int i = 0; i < DRW; i++) begin
            rdv[i] = jtag_tdo;
            drck_pulse(1'b0, 1'b1, wr[i]);
        end
        update_pulse(pop_with);
    endtask

    initial begin
        RST = 1'b1;
        {jtag_drck, jtag_sel, jtag_capture, jtag_shift, jtag_update, jtag_reset, jtag_tdi} = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        exp_ovf = 1'b0;

        // Reset with random TAP activity, then quiet inputs before release
        for (int i = 0; i < 3; i++) begin
            {jtag_drck, jtag_sel, jtag_capture, jtag_shift, jtag_update, jtag_reset, jtag_tdi} =
                7'($urandom_range(0, 127));
            tick(1);
        end
        {jtag_drck, jtag_sel, jtag_capture, jtag_shift, jtag_update, jtag_reset, jtag_tdi} = '0;
        tick(SS + 2);
        RST = 1'b0;
        tick(1);
        check("rst_tdo", 64'(jtag_tdo), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);

        // Host write
        scan(1'b1, mk_word(1'b1, 32'hDEADBEEF), rd, 0);
        exp_q.push_back(32'hDEADBEEF);
        tick(2);
        check("hw_out_valid", 64'(out_valid), 64'd1);
        pop_check("hw_data");
        check("hw_empty", 64'(out_valid), 64'd0);

        // Host read
        in_data = 32'h12345678;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        in_data = 32'hFFFF0000;
        check("hr_in_ready_lo", 64'(in_ready), 64'd0);
        scan(1'b1, mk_word(1'b0, 32'h0), rd, 0);
        check("hr_tdo_word", rd, cap_exp(1'b1, 1'b0, 1'b0, 32'h12345678));
        check("hr_in_ready_hi", 64'(in_ready), 64'd1);
        check("hr_no_push", 64'(out_valid), 64'd0);
        scan(1'b1, mk_word(1'b0, 32'h0), rd, 0);
        check("hr_second_cap", rd, cap_exp(1'b0, 1'b0, 1'b0, 32'h12345678));

        // Fill the FIFO, then push-with-pop when full, then a real drop
        for (int k = 0; k < DEPTH; k++) begin
            scan(1'b1, mk_word(1'b1, 32'hA0000000 + k), rd, 0);
            exp_q.push_back(32'hA0000000 + k);
        end
        check("fill_overflow", 64'(overflow), 64'd0);
        check("fill_valid", 64'(out_valid), 64'd1);
        scan(1'b1, mk_word(1'b1, 32'hA0000004), rd, 1);
        exp_q.push_back(32'hA0000004);
        check("full_pushpop_ovf", 64'(overflow), 64'd0);
        last_wr = mk_word(1'b1, 32'hA0000005);
        scan(1'b1, last_wr, rd, 0);
        exp_ovf = 1'b1;
        check("drop_overflow", 64'(overflow), 64'd1);
        for (int k = 0; k < DEPTH; k++) pop_check("drain");
        check("drain_empty", 64'(out_valid), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);

`ifdef BSCAN_DR_BRIDGE_STATUS_EN
        // Status capture and write-1-to-clear
        scan(1'b1, mk_word(1'b0, 32'h0), rd, 0);
        check("st_cap_ovf", rd, cap_exp(1'b0, 1'b0, 1'b1, 32'h12345678));
        last_wr = 64'd1 << OVFP;
        scan(1'b1, last_wr, rd, 0);
        exp_ovf = 1'b0;
        check("st_ovf_clear", 64'(overflow), 64'd0);
`endif

        // Deselected scan is ignored
        scan(1'b0, mk_word(1'b1, 32'h55AA55AA), rd, 0);
        check("desel_no_push", 64'(out_valid), 64'd0);
        check("desel_tdo", 64'(jtag_tdo), 64'(last_wr[0]));

        // TAP reset mid-shift clears the scan but keeps the FIFO
        scan(1'b1, mk_word(1'b1, 32'hC0FFEE11), rd, 0);
        exp_q.push_back(32'hC0FFEE11);
        jtag_sel = 1'b1;
        drck_pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DRW; i++) drck_pulse(1'b0, 1'b1, 1'b1);
        check("jr_tdo_before", 64'(jtag_tdo), 64'd1);
        jtag_reset = 1'b1;
        tick(SS + 2);
        check("jr_tdo_cleared", 64'(jtag_tdo), 64'd0);
        jtag_reset = 1'b0;
        tick(SS + 2);
        update_pulse(0);
        check("jr_fifo_intact", 64'(out_valid), 64'd1);
        check("jr_overflow", 64'(overflow), 64'(exp_ovf));
        pop_check("jr_data");
        check("jr_final_empty", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
